keystroke_buffer: RTL and testbench

Consumer end of the debounced-key interface. Accepts single-cycle keyReady strobes carrying savedByte values from the keyboard debouncer and queues each keystroke in a small FIFO. Applies backspace editing to unread entries and delivers bytes to downstream game/display logic over a valid/ready handshake. Sits between the keyboard debouncer and the typing/scoring logic.

---
 rtl/keytype_pkg.sv | 10 +
 rtl/keystroke_buffer_if.sv | 28 ++
 rtl/keystroke_ram.sv | 27 ++
 rtl/keystroke_buffer.sv | 100 ++++++++++
 tb/tb_keystroke_buffer.sv | 295 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/keytype_pkg.sv
// Keystroke types shared by the keyboard debouncer and the keystroke buffer.
// Holds the key byte type and the special key codes both ends agree on.
package keytype_pkg;

    typedef logic [7:0] key_byte_t;

    localparam key_byte_t KEY_RELEASED  = 8'h00;
    localparam key_byte_t KEY_BACKSPACE = 8'h08;

endpackage

// File: rtl/keystroke_buffer_if.sv
// Keystroke buffer bus: debouncer-side strobe, downstream valid/ready, status.
// slave = buffer side; master = producer/consumer side driving it.
interface keystroke_buffer_if #(
    parameter int DEPTH = 16
);
    import keytype_pkg::*;

    key_byte_t                      keyByte;
    logic                           keyReady;
    key_byte_t                      outByte;
    logic                           outValid;
    logic                           outReady;
    logic [$clog2(DEPTH+1)-1:0]     count;
    logic                           full;
    logic                           overflow;
    logic                           clearOverflow;

    modport slave (
        input  keyByte, keyReady, outReady, clearOverflow,
        output outByte, outValid, count, full, overflow
    );

    modport master (
        output keyByte, keyReady, outReady, clearOverflow,
        input  outByte, outValid, count, full, overflow
    );

endinterface

// File: rtl/keystroke_ram.sv
// Keystroke storage: DEPTH x key_byte_t, sync write, async read, no reset.
// Ports: clk, we/waddr/wdata write port, raddr/rdata read port.
module keystroke_ram
    import keytype_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
)(
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  key_byte_t     wdata,
    input  logic [AW-1:0] raddr,
    output key_byte_t     rdata
);

    key_byte_t mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/keystroke_buffer.sv
// Keystroke FIFO with zero-drop, backspace editing and sticky overflow.
// Ports: clk, RST (sync, active-high), bus (keystroke_buffer_if.slave).
module keystroke_buffer
    import keytype_pkg::*;
#(
    parameter int        DEPTH            = 16,
    parameter bit        DROP_ZERO        = 1'b1,
    parameter bit        ENABLE_BACKSPACE = 1'b1,
    parameter key_byte_t BACKSPACE_CODE   = KEY_BACKSPACE
)(
    input  logic                clk,
    input  logic                RST,
    keystroke_buffer_if.slave   bus
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    typedef logic [PW-1:0] ptr_t;
    typedef logic [CW-1:0] cnt_t;

    localparam cnt_t DEPTH_C = cnt_t'(DEPTH);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("keystroke_buffer: DEPTH must be a power of 2, >= 2");
    end

    ptr_t rd_ptr;
    ptr_t wr_ptr;
    cnt_t cnt;
    logic ovf;

    logic pop;
    cnt_t avail;
    logic ignore;
    logic bksp;
    logic push;
    logic wr_en;
    logic drop;
    logic erase;

    // Pop is resolved first so the key event sees the post-pop occupancy.
    always_comb begin
        pop    = (cnt != '0) && bus.outReady;
        avail  = cnt - cnt_t'(pop);
        ignore = !bus.keyReady
               || (DROP_ZERO && bus.keyByte == KEY_RELEASED);
        bksp   = !ignore && ENABLE_BACKSPACE
               && bus.keyByte == BACKSPACE_CODE;
        push   = !ignore && !bksp;
        wr_en  = push && (avail < DEPTH_C) && !RST;
        drop   = push && (avail >= DEPTH_C);
        // Erasing only touches entries not leaving this cycle.
        erase  = bksp && (avail != '0);
    end

    always_ff @(posedge clk) begin
        if (RST) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
            ovf    <= 1'b0;
        end else begin
            if (pop) begin
                rd_ptr <= rd_ptr + ptr_t'(1);
            end
            if (wr_en) begin
                wr_ptr <= wr_ptr + ptr_t'(1);
                cnt    <= avail + cnt_t'(1);
            end else if (erase) begin
                wr_ptr <= wr_ptr - ptr_t'(1);
                cnt    <= avail - cnt_t'(1);
            end else begin
                cnt    <= avail;
            end
            if (drop) begin
                ovf <= 1'b1;
            end else if (bus.clearOverflow) begin
                ovf <= 1'b0;
            end
        end
    end

    keystroke_ram #(
        .DEPTH (DEPTH)
    ) u_ram (
        .clk   (clk),
        .we    (wr_en),
        .waddr (wr_ptr),
        .wdata (bus.keyByte),
        .raddr (rd_ptr),
        .rdata (bus.outByte)
    );

    assign bus.outValid = (cnt != '0);
    assign bus.count    = cnt;
    assign bus.full     = (cnt == DEPTH_C);
    assign bus.overflow = ovf;

endmodule

// File: tb/tb_keystroke_buffer.sv
// Directed self-checking bench for keystroke_buffer (DEPTH=16).
// Inputs change 1ns after the rising edge; outputs are checked there too.
module tb_keystroke_buffer;

    logic clk = 1'b0;
    logic RST = 1'b1;
    int   checks = 0;
    int   errors = 0;

    keystroke_buffer_if #(.DEPTH(16)) bus ();

    keystroke_buffer #(
        .DEPTH            (16),
        .DROP_ZERO        (1'b1),
        .ENABLE_BACKSPACE (1'b1),
        .BACKSPACE_CODE   (8'h08)
    ) dut (
        .clk (clk),
        .RST (RST),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic key(input logic [7:0] b);
        bus.keyByte  = b;
        bus.keyReady = 1'b1;
        step();
        bus.keyReady = 1'b0;
    endtask

    task automatic do_reset();
        RST = 1'b1;
        step();
        RST = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (bus.outValid !== 1'b0) begin
            errors++;
            $display("FAIL reset_valid got %b want 0", bus.outValid);
        end
        checks++;
        if (bus.count !== 5'd0) begin
            errors++;
            $display("FAIL reset_count got %0d want 0", bus.count);
        end
        checks++;
        if (bus.full !== 1'b0 || bus.overflow !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags got full=%b ovf=%b want 0 0",
                     bus.full, bus.overflow);
        end
    endtask

    task automatic test_basic();
        logic [7:0] exp [3];
        exp = '{8'h41, 8'h42, 8'h43};
        bus.outReady = 1'b0;
        for (int i = 0; i < 3; i++) key(exp[i]);
        checks++;
        if (bus.count !== 5'd3 || bus.outValid !== 1'b1) begin
            errors++;
            $display("FAIL basic_fill got cnt=%0d v=%b want 3 1",
                     bus.count, bus.outValid);
        end
        bus.outReady = 1'b1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (bus.outByte !== exp[i] || bus.outValid !== 1'b1) begin
                errors++;
                $display("FAIL basic_out%0d got %h want %h",
                         i, bus.outByte, exp[i]);
            end
            step();
        end
        bus.outReady = 1'b0;
        checks++;
        if (bus.count !== 5'd0 || bus.outValid !== 1'b0) begin
            errors++;
            $display("FAIL basic_drain got cnt=%0d v=%b want 0 0",
                     bus.count, bus.outValid);
        end
    endtask

    task automatic test_filter();
        key(8'h00);
        key(8'h08);
        checks++;
        if (bus.count !== 5'd0 || bus.overflow !== 1'b0) begin
            errors++;
            $display("FAIL filter_empty got cnt=%0d ovf=%b want 0 0",
                     bus.count, bus.overflow);
        end
        key(8'h41);
        key(8'h42);
        key(8'h08);
        checks++;
        if (bus.count !== 5'd1 || bus.outByte !== 8'h41) begin
            errors++;
            $display("FAIL filter_bksp got cnt=%0d byte=%h want 1 41",
                     bus.count, bus.outByte);
        end
        bus.outReady = 1'b1;
        step();
        bus.outReady = 1'b0;
        checks++;
        if (bus.count !== 5'd0 || bus.outValid !== 1'b0) begin
            errors++;
            $display("FAIL filter_drain got cnt=%0d v=%b want 0 0",
                     bus.count, bus.outValid);
        end
    endtask

    task automatic test_overflow();
        logic [7:0] e;
        bus.outReady = 1'b0;
        for (int i = 0; i < 16; i++) key(8'h10 + 8'(i));
        checks++;
        if (bus.count !== 5'd16 || bus.full !== 1'b1) begin
            errors++;
            $display("FAIL ovf_fill got cnt=%0d full=%b want 16 1",
                     bus.count, bus.full);
        end
        key(8'h55);
        checks++;
        if (bus.overflow !== 1'b1 || bus.count !== 5'd16) begin
            errors++;
            $display("FAIL ovf_drop got ovf=%b cnt=%0d want 1 16",
                     bus.overflow, bus.count);
        end
        bus.outReady = 1'b1;
        key(8'h66);
        bus.outReady = 1'b0;
        checks++;
        if (bus.count !== 5'd16 || bus.outByte !== 8'h11) begin
            errors++;
            $display("FAIL ovf_pushpop got cnt=%0d byte=%h want 16 11",
                     bus.count, bus.outByte);
        end
        bus.outReady = 1'b1;
        for (int i = 0; i < 16; i++) begin
            e = (i == 15) ? 8'h66 : 8'h11 + 8'(i);
            checks++;
            if (bus.outByte !== e || bus.outValid !== 1'b1) begin
                errors++;
                $display("FAIL ovf_out%0d got %h want %h",
                         i, bus.outByte, e);
            end
            step();
        end
        bus.outReady = 1'b0;
        checks++;
        if (bus.count !== 5'd0 || bus.overflow !== 1'b1) begin
            errors++;
            $display("FAIL ovf_after got cnt=%0d ovf=%b want 0 1",
                     bus.count, bus.overflow);
        end
        bus.clearOverflow = 1'b1;
        step();
        bus.clearOverflow = 1'b0;
        checks++;
        if (bus.overflow !== 1'b0) begin
            errors++;
            $display("FAIL ovf_clear got %b want 0", bus.overflow);
        end
    endtask

    task automatic test_bksp_pop();
        key(8'h41);
        checks++;
        if (bus.outByte !== 8'h41 || bus.count !== 5'd1) begin
            errors++;
            $display("FAIL bkpop_pre got byte=%h cnt=%0d want 41 1",
                     bus.outByte, bus.count);
        end
        bus.outReady = 1'b1;
        key(8'h08);
        bus.outReady = 1'b0;
        checks++;
        if (bus.count !== 5'd0 || bus.outValid !== 1'b0) begin
            errors++;
            $display("FAIL bkpop_post got cnt=%0d v=%b want 0 0",
                     bus.count, bus.outValid);
        end
    endtask

    task automatic test_back_to_back();
        bus.outReady = 1'b1;
        for (int i = 0; i < 20; i++) begin
            key(8'h80 + 8'(i));
            checks++;
            if (bus.outByte !== 8'h80 + 8'(i) || bus.count !== 5'd1) begin
                errors++;
                $display("FAIL b2b_%0d got byte=%h cnt=%0d want %h 1",
                         i, bus.outByte, bus.count, 8'h80 + 8'(i));
            end
        end
        step();
        bus.outReady = 1'b0;
        checks++;
        if (bus.count !== 5'd0 || bus.overflow !== 1'b0) begin
            errors++;
            $display("FAIL b2b_end got cnt=%0d ovf=%b want 0 0",
                     bus.count, bus.overflow);
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 5; i++) key(8'h30 + 8'(i));
        checks++;
        if (bus.count !== 5'd5) begin
            errors++;
            $display("FAIL rstmid_pre got %0d want 5", bus.count);
        end
        RST          = 1'b1;
        bus.keyByte  = 8'h99;
        bus.keyReady = 1'b1;
        step();
        RST          = 1'b0;
        bus.keyReady = 1'b0;
        checks++;
        if (bus.count !== 5'd0 || bus.outValid !== 1'b0 ||
            bus.overflow !== 1'b0) begin
            errors++;
            $display("FAIL rstmid got cnt=%0d v=%b ovf=%b want 0 0 0",
                     bus.count, bus.outValid, bus.overflow);
        end
        key(8'h21);
        checks++;
        if (bus.count !== 5'd1 || bus.outByte !== 8'h21) begin
            errors++;
            $display("FAIL rstmid_next got cnt=%0d byte=%h want 1 21",
                     bus.count, bus.outByte);
        end
        do_reset();
    endtask

    task automatic test_clear_drop();
        for (int i = 0; i < 16; i++) key(8'h40 + 8'(i));
        bus.clearOverflow = 1'b1;
        key(8'h77);
        checks++;
        if (bus.overflow !== 1'b1 || bus.count !== 5'd16) begin
            errors++;
            $display("FAIL clrdrop got ovf=%b cnt=%0d want 1 16",
                     bus.overflow, bus.count);
        end
        step();
        bus.clearOverflow = 1'b0;
        checks++;
        if (bus.overflow !== 1'b0) begin
            errors++;
            $display("FAIL clrdrop_clear got %b want 0", bus.overflow);
        end
        checks++;
        if (bus.outByte !== 8'h40) begin
            errors++;
            $display("FAIL clrdrop_head got %h want 40", bus.outByte);
        end
        do_reset();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.keyByte       = 8'h00;
        bus.keyReady      = 1'b0;
        bus.outReady      = 1'b0;
        bus.clearOverflow = 1'b0;
        test_reset();
        test_basic();
        test_filter();
        test_overflow();
        test_bksp_pop();
        test_back_to_back();
        test_reset_mid();
        test_clear_drop();
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
